// File: rtl/nvram_pkg.sv
// ============================================================================
// nvram_pkg : shared types and constants for the NVRAM upload path
// Rev 1.0
// ============================================================================
`default_nettype none

package nvram_pkg;

   localparam logic [7:0] DIN_OOR          = 8'hFF;
   localparam logic [7:0] UPLOAD_INDEX_DEF = 8'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAUSE   = 3'd1,
      ST_READY   = 3'd2,
      ST_FETCH   = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/nvram_upload_edge_pulse.sv
// ============================================================================
// edge_pulse : single-cycle rising-edge detector
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) r_prev <= 1'b0;
      else       r_prev <= i_sig;
   end

   assign o_rise = i_sig & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/nvram_upload.sv
// ============================================================================
// nvram_upload : serves core RAM bytes to the HPS over the ioctl upload channel
// Rev 1.0
// ============================================================================
`default_nettype none

module nvram_upload
   import nvram_pkg::*;
#(
   parameter int         ADDR_W       = 12,
   parameter logic [7:0] UPLOAD_INDEX = UPLOAD_INDEX_DEF,
   parameter int         RAM_LAT      = 2,
   parameter int         BASE         = 0,
   parameter int         LEN          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_upload_req,
   input  logic              autosave,
   input  logic              osd_open,
   input  logic              ram_dirty,
   output logic              pause_req,
   input  logic              paused,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [7:0]        ram_q,
   output logic              busy
);

   localparam logic [1:0]  C_LAT = 2'(RAM_LAT);
   localparam logic [24:0] C_LEN = 25'(LEN);

   state_e              r_state;
   logic [1:0]          r_cnt;
   logic [7:0]          r_din;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_pend;
   logic [24:0]         r_q_off;
   logic                r_ovr;
   logic                r_dirty;
   logic                r_req;

   logic                w_sel;
   logic                w_sel_rise;
   logic                w_osd_rise;
   logic                w_track;
   logic                w_serve;
   logic                w_take_new;
   logic [24:0]         w_off;
   logic                w_in_range;
   logic                w_cap;

   assign w_sel = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

   edge_pulse u_sel_edge (.clk(clk), .reset(reset), .i_sig(w_sel),    .o_rise(w_sel_rise));
   edge_pulse u_osd_edge (.clk(clk), .reset(reset), .i_sig(osd_open), .o_rise(w_osd_rise));

   // A queued strobe always wins over a fresh one so requests are served in order
   assign w_track    = (r_state == ST_PAUSE) || (r_state == ST_READY) || (r_state == ST_FETCH);
   assign w_serve    = (r_state == ST_READY) && w_sel && paused && (r_pend || ioctl_rd);
   assign w_take_new = w_serve && !r_pend && ioctl_rd;
   assign w_off      = r_pend ? r_q_off : ioctl_addr;
   assign w_in_range = (w_off < C_LEN);
   assign w_cap      = (r_state == ST_FETCH) && (r_cnt == C_LAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 2'd0;
         r_din   <= 8'd0;
         r_addr  <= ADDR_W'(BASE);
      end else begin
         case (r_state)
            ST_IDLE: if (w_sel_rise) r_state <= ST_PAUSE;
            ST_PAUSE: begin
               if (!w_sel)      r_state <= ST_RELEASE;
               else if (paused) r_state <= ST_READY;
            end
            ST_READY: begin
               if (!w_sel)       r_state <= ST_RELEASE;
               else if (!paused) r_state <= ST_PAUSE;
               else if (w_serve) begin
                  if (w_in_range) begin
                     r_addr  <= ADDR_W'(BASE) + w_off[ADDR_W-1:0];
                     r_cnt   <= 2'd0;
                     r_state <= ST_FETCH;
                  end else begin
                     r_din <= DIN_OOR;
                  end
               end
            end
            // ram_rd is dropped on the capture cycle; data is already in the RAM pipe
            ST_FETCH: begin
               if (w_cap) begin
                  r_din   <= ram_q;
                  r_state <= paused ? ST_READY : ST_PAUSE;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            ST_RELEASE: r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !w_track) begin
         r_pend  <= 1'b0;
         r_q_off <= 25'd0;
      end else if (ioctl_rd && !w_take_new) begin
         if (!(r_pend && !w_serve)) begin
            r_pend  <= 1'b1;
            r_q_off <= ioctl_addr;
         end
      end else if (w_serve && r_pend) begin
         r_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_ovr <= 1'b0;
      else       r_ovr <= r_ovr | (w_track && ioctl_rd && r_pend && !w_serve);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dirty <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         if (ram_dirty)       r_dirty <= 1'b1;
         else if (w_sel_rise) r_dirty <= 1'b0;
         r_req <= w_osd_rise && autosave && r_dirty && (r_state == ST_IDLE);
      end
   end

   assign ioctl_din        = r_din;
   assign ioctl_upload_req = r_req;
   assign ram_addr         = r_addr;
   assign ram_rd           = (r_state == ST_FETCH) && (r_cnt < C_LAT);
   assign pause_req        = w_track;
   assign busy             = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_nvram_upload.sv
// ============================================================================
// tb_nvram_upload : directed self-checking bench for nvram_upload
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nvram_upload;
   import nvram_pkg::*;

   localparam int ADDR_W  = 12;
   localparam int RAM_LAT = 2;
   localparam int BASE    = 0;
   localparam int LEN     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              ioctl_upload;
   logic [7:0]        ioctl_index;
   logic              ioctl_rd;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_din;
   logic              ioctl_upload_req;
   logic              autosave;
   logic              osd_open;
   logic              ram_dirty;
   logic              pause_req;
   logic              paused;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic [7:0]        ram_q;
   logic              busy;

   nvram_upload #(
      .ADDR_W(ADDR_W), .UPLOAD_INDEX(8'd4), .RAM_LAT(RAM_LAT), .BASE(BASE), .LEN(LEN)
   ) dut (
      .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
      .ioctl_upload_req(ioctl_upload_req), .autosave(autosave), .osd_open(osd_open),
      .ram_dirty(ram_dirty), .pause_req(pause_req), .paused(paused), .ram_addr(ram_addr),
      .ram_rd(ram_rd), .ram_q(ram_q), .busy(busy)
   );

   always #5 clk = ~clk;

   // RAM model: data appears RAM_LAT register stages after the address
   logic [7:0] mem [0:(1<<ADDR_W)-1];
   logic [7:0] r_p1, r_p2;
   always @(posedge clk) begin
      r_p1 <= mem[ram_addr];
      r_p2 <= r_p1;
   end
   assign ram_q = r_p2;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb [$];

   task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_din(input string tag);
      logic [7:0] e;
      check({tag, "_sb"}, 25'(sb.size() != 0), 25'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check(tag, 25'(ioctl_din), 25'(e));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic saw;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 7 + 1);
      mem[BASE + 0]  = 8'h5A;
      mem[BASE + 1]  = 8'hC3;
      mem[BASE + 3]  = 8'hA5;
      mem[BASE + 15] = 8'h7E;

      reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
      ioctl_addr = 25'd0; autosave = 1'b0; osd_open = 1'b0; ram_dirty = 1'b0; paused = 1'b0;
      tick(); tick();
      check("rst_din",  25'(ioctl_din), 25'd0);
      check("rst_req",  25'(ioctl_upload_req), 25'd0);
      check("rst_pause",25'(pause_req), 25'd0);
      check("rst_addr", 25'(ram_addr), 25'(BASE));
      check("rst_rd",   25'(ram_rd), 25'd0);
      check("rst_busy", 25'(busy), 25'd0);
      reset = 1'b0;
      tick();

      // sel rise while CPU refuses to pause
      ioctl_index = 8'd4; ioctl_upload = 1'b1;
      tick();
      check("sel_pause_req", 25'(pause_req), 25'd1);
      check("sel_busy",      25'(busy), 25'd1);
      saw = 1'b0;
      repeat (100) begin tick(); saw |= ram_rd; end
      check("wait_no_rd", 25'(saw), 25'd0);
      check("wait_state", 25'(dut.r_state), 25'(ST_PAUSE));
      paused = 1'b1;
      tick();
      check("ready_state", 25'(dut.r_state), 25'(ST_READY));

      // single fetch at offset 3
      ioctl_addr = 25'd3; ioctl_rd = 1'b1; sb.push_back(8'hA5);
      tick(); ioctl_rd = 1'b0;
      check("f3_addr", 25'(ram_addr), 25'(BASE + 3));
      check("f3_rd1",  25'(ram_rd), 25'd1);
      tick(); check("f3_rd2", 25'(ram_rd), 25'd1);
      tick(); check("f3_rd3", 25'(ram_rd), 25'd0);
      tick(); pop_din("f3_din");

      // out of range and last valid byte
      ioctl_addr = 25'(LEN); ioctl_rd = 1'b1;
      tick(); ioctl_rd = 1'b0;
      check("oor_din", 25'(ioctl_din), 25'(DIN_OOR));
      check("oor_rd",  25'(ram_rd), 25'd0);
      ioctl_addr = 25'(LEN - 1); ioctl_rd = 1'b1; sb.push_back(8'h7E);
      tick(); ioctl_rd = 1'b0;
      tick(); tick(); tick(); pop_din("last_din");
      ioctl_addr = 25'h100003; ioctl_rd = 1'b1;
      tick(); ioctl_rd = 1'b0;
      check("hibits_din", 25'(ioctl_din), 25'(DIN_OOR));

      // back-to-back strobes, second one queued behind the first fetch
      ioctl_addr = 25'd0; ioctl_rd = 1'b1; sb.push_back(8'h5A);
      tick();
      ioctl_addr = 25'd1; sb.push_back(8'hC3);
      tick(); ioctl_rd = 1'b0;
      tick(); tick(); pop_din("b2b_byte0");
      tick(); tick(); tick();
      check("b2b_hold", 25'(ioctl_din), 25'h5A);
      tick(); pop_din("b2b_byte1");
      check("b2b_ovr", 25'(dut.r_ovr), 25'd0);

      // sel drop in READY
      ioctl_upload = 1'b0;
      tick();
      check("rel_state", 25'(dut.r_state), 25'(ST_RELEASE));
      check("rel_pause", 25'(pause_req), 25'd0);
      tick();
      check("rel_idle_busy", 25'(busy), 25'd0);
      paused = 1'b0;

      // autosave upload request
      ram_dirty = 1'b1; tick(); ram_dirty = 1'b0;
      autosave = 1'b1; osd_open = 1'b1;
      tick(); check("req_pulse", 25'(ioctl_upload_req), 25'd1);
      tick(); check("req_one_cycle", 25'(ioctl_upload_req), 25'd0);
      osd_open = 1'b0; tick();
      autosave = 1'b0; osd_open = 1'b1;
      tick(); check("req_no_autosave", 25'(ioctl_upload_req), 25'd0);
      osd_open = 1'b0; autosave = 1'b1; tick();

      // dirty pulse coincident with sel rise keeps the flag; busy blocks request
      ioctl_upload = 1'b1; ram_dirty = 1'b1;
      tick(); ram_dirty = 1'b0;
      osd_open = 1'b1;
      tick(); check("req_busy", 25'(ioctl_upload_req), 25'd0);
      osd_open = 1'b0; ioctl_upload = 1'b0;
      tick(); tick();
      osd_open = 1'b1;
      tick(); check("req_dirty_kept", 25'(ioctl_upload_req), 25'd1);
      osd_open = 1'b0;
      ioctl_upload = 1'b1; tick();
      ioctl_upload = 1'b0; tick(); tick();
      osd_open = 1'b1;
      tick(); check("req_dirty_clr", 25'(ioctl_upload_req), 25'd0);
      osd_open = 1'b0;

      // reset in the middle of a fetch
      ioctl_upload = 1'b1; paused = 1'b1;
      tick(); tick();
      ioctl_addr = 25'd2; ioctl_rd = 1'b1;
      tick(); ioctl_rd = 1'b0;
      check("rf_rd", 25'(ram_rd), 25'd1);
      reset = 1'b1; ioctl_upload = 1'b0;
      tick();
      check("rf_pause", 25'(pause_req), 25'd0);
      check("rf_rd0",   25'(ram_rd), 25'd0);
      check("rf_din",   25'(ioctl_din), 25'd0);
      check("rf_busy",  25'(busy), 25'd0);
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
